yarp_div: RTL and testbench
===========================

Name: yarp_div

Overview:
- Iterative RV32M divide unit (DIV, DIVU, REM, REMU) in the YARP execute stage.
- Consumes rs1/rs2 read data from the register file and drives the register file write port (wr_en/rd_addr/wr_data) directly on completion.
- Radix-2 restoring algorithm, one quotient bit per cycle; core stalls while ready_o is low.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITERS, 32, division iterations; must equal XLEN.

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start_i  input  1  request; accepted on a rising edge when ready_o=1 and flush_i=0.
- op_i  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- rs1_data_i  input  32  dividend, from register file rs1_data_o.
- rs2_data_i  input  32  divisor, from register file rs2_data_o.
- rd_addr_i  input  5  destination register.
- flush_i  input  1  abort any in-flight operation.
- ready_o  output  1  unit idle; can accept start_i.
- done_o  output  1  one-cycle completion pulse; asserted even when rd=x0.
- wr_en_o  output  1  register file write enable; equals done_o AND rd_addr_o!=0.
- rd_addr_o  output  5  latched destination register.
- wr_data_o  output  32  result: quotient or remainder.

Behaviour:
- Operands, op and rd are latched at the accepting edge; inputs are don't-care afterwards.
- Reset:
  - After a reset edge: state=IDLE, counter=0, done_o=0, wr_en_o=0, rd_addr_o=0, wr_data_o=0.
  - ready_o=0 while reset is high, 1 in IDLE otherwise.
- States:
  - IDLE -> CALC on accept (normal case).
  - IDLE -> DONE on accept (special case).
  - CALC -> DONE after the 32nd iteration edge.
  - DONE -> IDLE unconditionally.
- ready_o is 1 only in IDLE. done_o is 1 only in DONE.
- Latency (accept cycle = cycle 0):
  - Normal: done_o high in cycle 33.
  - Special case: done_o high in cycle 1.
  - Next start can be accepted in the cycle after DONE.
- Signed ops (DIV/REM):
  - Divide the magnitudes.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the dividend's sign.
  - Unsigned ops divide raw values.
- Special cases, resolved with no CALC:
  - Divisor = 0: quotient = 0xFFFFFFFF; remainder = dividend (all ops).
  - DIV/REM with 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- CALC iteration:
  - Shift {rem, quo} left by 1 and bring in the next dividend MSB.
  - If rem >= divisor magnitude: subtract, set quotient bit to 1.
  - Use a 33-bit compare; no overflow is possible.
  - Counter runs 0..31; there is no wrap beyond 31.
- Results: wr_data_o and rd_addr_o are registered and stable throughout DONE, and are held (not cleared) in IDLE.
- rd_addr 0: done_o pulses, wr_en_o stays 0.
- start_i while not ready is ignored and not queued.
- flush_i:
  - In any state, next state = IDLE and counter = 0.
  - Suppresses done_o/wr_en_o for the aborted operation; if already in DONE in that cycle, the pulse still occurs (write already committed).
  - flush_i with start_i in IDLE: flush wins, nothing accepted.
- reset mid-operation: aborts identically to flush; no write is issued.

Optional Feature:
- Macro: YARP_DIV_EARLY_OUT_EN.
- Defined: at accept, if |dividend| < |divisor| (divisor nonzero), go IDLE->DONE with quotient = 0 and remainder = dividend (original signed value for REM); latency 1.
- Undefined: these cases run the full 32 iterations, latency 33; results are identical.

Test Plan:
- DIVU 100/7, rd=5 -> done_o and wr_en_o in cycle 33, rd_addr_o=5, wr_data_o=14; repeat with REMU -> 2.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIV 7 / 0xFFFFFFFE -> 0xFFFFFFFD; REM -> 1.
- DIVU 0x1234/0 -> 0xFFFFFFFF in cycle 1; REMU 0x1234/0 -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 in cycle 1; REM -> 0.
- Start DIVU 1000/3; flush_i in cycle 10 -> no done_o/wr_en_o; ready_o=1 in cycle 11; a start_i pulsed in cycle 5 is ignored.
- DIVU 50/5 with rd=0 -> done_o in cycle 33, wr_en_o=0; reset asserted in cycle 20 of another op -> no write, ready_o=1 after reset deasserts.
- DIVU 3/10: with YARP_DIV_EARLY_OUT_EN -> done_o in cycle 1, data 0; without it -> cycle 33, data 0; REMU -> 3 in both builds.

Source files
------------

// File: rtl/yarp_div_if.sv
// yarp_div_if: request/response bundle between the YARP execute stage and
// the iterative divide unit.
//
// Signals (named from the divider's point of view):
//   start_i     request, accepted when ready_o=1 and flush_i=0
//   op_i        00 DIV, 01 DIVU, 10 REM, 11 REMU
//   rs1_data_i  dividend
//   rs2_data_i  divisor
//   rd_addr_i   destination register
//   flush_i     abort any in-flight operation
//   ready_o     unit idle
//   done_o      one-cycle completion pulse
//   wr_en_o     register file write enable
//   rd_addr_o   latched destination register
//   wr_data_o   quotient or remainder
//
// Modports: master (execute stage / bench) drives requests,
//           slave (divider) drives responses.
interface yarp_div_if;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [4:0]  rd_addr_i;
  logic        flush_i;
  logic        ready_o;
  logic        done_o;
  logic        wr_en_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] wr_data_o;

  modport master (
    output start_i, op_i, rs1_data_i, rs2_data_i, rd_addr_i, flush_i,
    input  ready_o, done_o, wr_en_o, rd_addr_o, wr_data_o
  );

  modport slave (
    input  start_i, op_i, rs1_data_i, rs2_data_i, rd_addr_i, flush_i,
    output ready_o, done_o, wr_en_o, rd_addr_o, wr_data_o
  );
endinterface

// File: rtl/yarp_div.sv
// yarp_div: iterative RV32M divide unit (DIV, DIVU, REM, REMU).
// Radix-2 restoring division, one quotient bit per cycle. Divide-by-zero
// and signed overflow resolve straight to DONE (latency 1); all other
// operations take 32 CALC cycles (done_o in cycle 33 after accept).
//
// Ports:
//   clk    core clock, rising edge
//   reset  synchronous active-high reset
//   bus    yarp_div_if.slave (request in, register file write out)
//
// Optional feature macro: YARP_DIV_EARLY_OUT_EN
//   When defined, |dividend| < |divisor| (divisor nonzero) also resolves
//   at accept with quotient 0 / remainder = dividend.
module yarp_div #(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input logic       clk,
  input logic       reset,
  yarp_div_if.slave bus
);

  localparam int CW = $clog2(ITERS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          r_state, w_state_next;
  logic [CW-1:0]   r_cnt, w_cnt_next;

  logic [XLEN-1:0] r_rem, r_quo, r_div;
  logic            r_neg_q, r_neg_r, r_op_rem;
  logic [4:0]      r_rd_pend, r_rd_addr;
  logic [XLEN-1:0] r_wr_data;

  // ---------------- accept-time decode ----------------
  logic            w_accept, w_signed, w_div_zero, w_ovf, w_early, w_special;
  logic [XLEN-1:0] w_a, w_b, w_a_mag, w_b_mag;
  logic [XLEN-1:0] w_spec_quo, w_spec_rem, w_spec_res;

  assign w_accept   = (r_state == ST_IDLE) && bus.start_i && !bus.flush_i;
  assign w_signed   = !bus.op_i[0];
  assign w_a        = bus.rs1_data_i;
  assign w_b        = bus.rs2_data_i;
  assign w_a_mag    = (w_signed && w_a[XLEN-1]) ? -w_a : w_a;
  assign w_b_mag    = (w_signed && w_b[XLEN-1]) ? -w_b : w_b;
  assign w_div_zero = (w_b == '0);
  assign w_ovf      = w_signed && (w_a == {1'b1, {(XLEN-1){1'b0}}}) && (w_b == '1);

`ifdef YARP_DIV_EARLY_OUT_EN
  assign w_early    = !w_div_zero && (w_a_mag < w_b_mag);
`else
  assign w_early    = 1'b0;
`endif

  assign w_special  = w_div_zero || w_ovf || w_early;

  always_comb begin
    w_spec_quo = '0;
    w_spec_rem = w_a;
    if (w_div_zero) begin
      w_spec_quo = '1;
      w_spec_rem = w_a;
    end else if (w_ovf) begin
      w_spec_quo = {1'b1, {(XLEN-1){1'b0}}};
      w_spec_rem = '0;
    end
  end

  assign w_spec_res = bus.op_i[1] ? w_spec_rem : w_spec_quo;

  // ---------------- one restoring step ----------------
  // Partial remainder stays below the divisor, so the shifted value fits in
  // XLEN+1 bits and bit XLEN of the difference is a clean borrow flag.
  logic [XLEN:0]   w_shift, w_diff;
  logic            w_ge, w_last;
  logic [XLEN-1:0] w_rem_step, w_quo_step, w_final;

  assign w_shift    = {r_rem, r_quo[XLEN-1]};
  assign w_diff     = w_shift - {1'b0, r_div};
  assign w_ge       = !w_diff[XLEN];
  assign w_rem_step = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
  assign w_quo_step = {r_quo[XLEN-2:0], w_ge};
  assign w_last     = (r_cnt == CW'(ITERS-1));
  assign w_final    = r_op_rem ? (r_neg_r ? -w_rem_step : w_rem_step)
                               : (r_neg_q ? -w_quo_step : w_quo_step);

  // ---------------- FSM ----------------
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        w_cnt_next = '0;
        if (w_accept) w_state_next = w_special ? ST_DONE : ST_CALC;
      end
      ST_CALC: begin
        if (w_last) begin
          w_state_next = ST_DONE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = r_cnt + 1'b1;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
    if (bus.flush_i) begin
      w_state_next = ST_IDLE;
      w_cnt_next   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // ---------------- datapath ----------------
  // Result and rd outputs only change when an operation commits, so an
  // aborted operation leaves the previous result visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem     <= '0;
      r_quo     <= '0;
      r_div     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_op_rem  <= 1'b0;
      r_rd_pend <= '0;
      r_rd_addr <= '0;
      r_wr_data <= '0;
    end else if (w_accept) begin
      r_rem     <= '0;
      r_quo     <= w_a_mag;
      r_div     <= w_b_mag;
      r_neg_q   <= w_signed && (w_a[XLEN-1] ^ w_b[XLEN-1]);
      r_neg_r   <= w_signed && w_a[XLEN-1];
      r_op_rem  <= bus.op_i[1];
      r_rd_pend <= bus.rd_addr_i;
      if (w_special) begin
        r_wr_data <= w_spec_res;
        r_rd_addr <= bus.rd_addr_i;
      end
    end else if ((r_state == ST_CALC) && !bus.flush_i) begin
      r_rem <= w_rem_step;
      r_quo <= w_quo_step;
      if (w_last) begin
        r_wr_data <= w_final;
        r_rd_addr <= r_rd_pend;
      end
    end
  end

  assign bus.ready_o   = (r_state == ST_IDLE) && !reset;
  assign bus.done_o    = (r_state == ST_DONE);
  assign bus.wr_en_o   = (r_state == ST_DONE) && (r_rd_addr != 5'd0);
  assign bus.rd_addr_o = r_rd_addr;
  assign bus.wr_data_o = r_wr_data;

endmodule

// File: tb/tb_yarp_div.sv
module tb_yarp_div;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  yarp_div_if bus ();

  yarp_div #(.XLEN(32), .ITERS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  // Reference: plain 64-bit arithmetic (SV / and % truncate toward zero,
  // remainder takes the dividend's sign), RISC-V rules for divide by zero.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return op[1] ? r[31:0] : q[31:0];
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    longint sa, sb;
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    sa = !op[0] ? longint'($signed(a)) : longint'({32'd0, a});
    sb = !op[0] ? longint'($signed(b)) : longint'({32'd0, b});
    if (sa < 0) sa = -sa;
    if (sb < 0) sb = -sb;
`ifdef YARP_DIV_EARLY_OUT_EN
    if (sa < sb) return 1;
`endif
    return 33;
  endfunction

  task automatic drive_idle();
    bus.start_i    = 1'b0;
    bus.flush_i    = 1'b0;
    bus.op_i       = 2'b00;
    bus.rs1_data_i = 32'd0;
    bus.rs2_data_i = 32'd0;
    bus.rd_addr_i  = 5'd0;
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
    int lat;
    logic [31:0] exp_d;
    int exp_lat;
    exp_d   = ref_result(op, a, b);
    exp_lat = ref_latency(op, a, b);
    @(negedge clk);
    check({tag, ":ready"}, 32'(bus.ready_o), 32'd1);
    bus.start_i = 1'b1; bus.op_i = op; bus.rs1_data_i = a; bus.rs2_data_i = b;
    bus.rd_addr_i = rd;
    @(posedge clk);
    #1;
    // Scramble inputs after accept: they must be don't-care now.
    bus.start_i = 1'b0; bus.rs1_data_i = $urandom; bus.rs2_data_i = $urandom;
    bus.op_i = 2'($urandom); bus.rd_addr_i = 5'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.done_o && lat < 40);
    check({tag, ":done"},    32'(bus.done_o),    32'd1);
    check({tag, ":latency"}, 32'(lat),           32'(exp_lat));
    check({tag, ":data"},    bus.wr_data_o,      exp_d);
    check({tag, ":rd"},      32'(bus.rd_addr_o), 32'(rd));
    check({tag, ":wr_en"},   32'(bus.wr_en_o),   32'(rd != 5'd0));
    @(negedge clk);
    check({tag, ":pulse"},   32'(bus.done_o),    32'd0);
    check({tag, ":hold"},    bus.wr_data_o,      exp_d);
    $display("op=%0d a=0x%08h b=0x%08h rd=%0d -> data=0x%08h lat=%0d (exp 0x%08h/%0d)",
             op, a, b, rd, bus.wr_data_o, lat, exp_d, exp_lat);
  endtask

  // Count done_o / wr_en_o pulses over n cycles (aborted-operation checks).
  task automatic count_done(input int n, output int dones, output int wrs);
    dones = 0; wrs = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.done_o) dones++;
      if (bus.wr_en_o) wrs++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int dones, wrs;
    logic [31:0] prev;
    drive_idle();
    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst:ready",   32'(bus.ready_o),   32'd0);
    check("rst:done",    32'(bus.done_o),    32'd0);
    check("rst:wr_en",   32'(bus.wr_en_o),   32'd0);
    check("rst:rd",      32'(bus.rd_addr_o), 32'd0);
    check("rst:data",    bus.wr_data_o,      32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst:ready_after", 32'(bus.ready_o), 32'd1);

    // ---- directed cases ----
    run_op("divu_100_7",  2'b01, 32'd100, 32'd7, 5'd5);
    run_op("remu_100_7",  2'b11, 32'd100, 32'd7, 5'd5);
    run_op("div_m7_2",    2'b00, 32'hFFFF_FFF9, 32'd2, 5'd3);
    run_op("rem_m7_2",    2'b10, 32'hFFFF_FFF9, 32'd2, 5'd3);
    run_op("div_7_m2",    2'b00, 32'd7, 32'hFFFF_FFFE, 5'd4);
    run_op("rem_7_m2",    2'b10, 32'd7, 32'hFFFF_FFFE, 5'd4);
    run_op("divu_by0",    2'b01, 32'h1234, 32'd0, 5'd6);
    run_op("remu_by0",    2'b11, 32'h1234, 32'd0, 5'd6);
    run_op("div_by0",     2'b00, 32'hFFFF_FF00, 32'd0, 5'd7);
    run_op("div_ovf",     2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
    run_op("rem_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
    run_op("divu_3_10",   2'b01, 32'd3, 32'd10, 5'd9);
    run_op("remu_3_10",   2'b11, 32'd3, 32'd10, 5'd9);
    run_op("rem_m3_10",   2'b10, 32'hFFFF_FFFD, 32'd10, 5'd9);
    run_op("divu_big",    2'b01, 32'hFFFF_FFFF, 32'd1, 5'd31);
    run_op("divu_rd0",    2'b01, 32'd50, 32'd5, 5'd0);

    // ---- flush mid-operation, start while busy ignored ----
    prev = bus.wr_data_o;
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = 2'b01; bus.rs1_data_i = 32'd1000;
    bus.rs2_data_i = 32'd3; bus.rd_addr_i = 5'd12;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    dones = 0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (bus.done_o) dones++;
      if (c == 5) begin bus.start_i = 1'b1; bus.rs1_data_i = 32'd9; bus.rs2_data_i = 32'd0; end
      if (c == 6) bus.start_i = 1'b0;
      if (c == 10) bus.flush_i = 1'b1;
      if (c == 11) begin
        check("flush:ready_c11", 32'(bus.ready_o), 32'd1);
        bus.flush_i = 1'b0;
      end
    end
    count_done(40, wrs, dones);
    check("flush:no_done", 32'(dones + wrs), 32'd0);
    check("flush:data_kept", bus.wr_data_o, prev);

    // ---- flush together with start in IDLE: flush wins ----
    @(negedge clk);
    bus.start_i = 1'b1; bus.flush_i = 1'b1; bus.rs1_data_i = 32'd5; bus.rs2_data_i = 32'd0;
    bus.rd_addr_i = 5'd2;
    @(negedge clk);
    bus.start_i = 1'b0; bus.flush_i = 1'b0;
    check("flushstart:ready", 32'(bus.ready_o), 32'd1);
    count_done(36, dones, wrs);
    check("flushstart:no_done", 32'(dones), 32'd0);

    // ---- reset mid-operation ----
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = 2'b01; bus.rs1_data_i = 32'd777;
    bus.rs2_data_i = 32'd10; bus.rd_addr_i = 5'd17;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    for (int c = 1; c <= 20; c++) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst:ready_low", 32'(bus.ready_o), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst:ready_high", 32'(bus.ready_o), 32'd1);
    check("midrst:data_clr", bus.wr_data_o, 32'd0);
    count_done(40, dones, wrs);
    check("midrst:no_write", 32'(dones + wrs), 32'd0);

    // ---- randomized operations ----
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      logic [4:0]  rd;
      op = 2'($urandom);
      a  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 20));
        3: b = -32'($urandom_range(1, 20));
        4: begin b = $urandom; a = a >> $urandom_range(0, 31); end
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      run_op($sformatf("rand%0d", i), op, a, b, rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
